rom_port_arbiter: RTL

Two-requester arbiter and response buffer in front of the single-port instruction ROM. It shares the ROM read port between the instruction-fetch stage (port IF) and the AXI-Lite debug read path (port DBG). It drives the ROM's `ce`/`addr` inputs, registers `inst` into a per-port response buffer, and returns data with a valid/ready handshake. It sits between the core's fetch logic / AXI-Lite slave and the ROM instance.

---
 rtl/rom_port_arbiter_if.sv | 44 ++++
 rtl/rom_port_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two ROM requesters (IF, DBG), the arbiter and the ROM read port.
// The arbiter owns the slave modport; requesters and the ROM model sit on the master side.
interface rom_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_err_o;
  logic                  if_rready_i;

  logic                  dbg_req_i;
  logic [ADDR_WIDTH-1:0] dbg_addr_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [DATA_WIDTH-1:0] dbg_rdata_o;
  logic                  dbg_err_o;
  logic                  dbg_rready_i;

  logic                  rom_ce_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_inst_i;

  modport slave (
    input  if_req_i, if_addr_i, if_rready_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  dbg_req_i, dbg_addr_i, dbg_rready_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    output rom_ce_o, rom_addr_o,
    input  rom_inst_i
  );

  modport master (
    output if_req_i, if_addr_i, if_rready_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output dbg_req_i, dbg_addr_i, dbg_rready_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    input  rom_ce_o, rom_addr_o,
    output rom_inst_i
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the single-port instruction ROM between IF and DBG with one-deep response buffers.
// Define ROM_ARB_FIXED_PRIO_EN for strict IF priority; otherwise round-robin arbitration.
module rom_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE_WIDTH = 17
) (
  input logic              clk,
  input logic              rst,
  rom_port_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t            if_state, if_state_next;
  buf_state_t            dbg_state, dbg_state_next;
  logic                  if_elig, dbg_elig;
  logic                  if_gnt, dbg_gnt;
  logic                  if_drain, dbg_drain;
  logic [DATA_WIDTH-1:0] if_rdata, dbg_rdata;
  logic                  if_err, dbg_err;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  gnt_err;
  logic [DATA_WIDTH-1:0] load_data;

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (MEM_SIZE_WIDTH + 2)) != '0);
  endfunction

  // A full buffer that is drained this cycle can accept a refill in the same cycle.
  assign if_drain  = (if_state == FULL) && bus.if_rready_i;
  assign dbg_drain = (dbg_state == FULL) && bus.dbg_rready_i;
  assign if_elig   = bus.if_req_i && ((if_state == EMPTY) || bus.if_rready_i);
  assign dbg_elig  = bus.dbg_req_i && ((dbg_state == EMPTY) || bus.dbg_rready_i);

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic last;

  // last = 1 means DBG was granted most recently, so IF wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (if_gnt) begin
      last <= 1'b0;
    end else if (dbg_gnt) begin
      last <= 1'b1;
    end
  end
`endif

  always_comb begin
    if_gnt         = 1'b0;
    dbg_gnt        = 1'b0;
    if_state_next  = if_state;
    dbg_state_next = dbg_state;

    if (!rst) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      if_gnt  = if_elig;
      dbg_gnt = dbg_elig && !if_elig;
`else
      if (if_elig && dbg_elig) begin
        if_gnt  = last;
        dbg_gnt = !last;
      end else begin
        if_gnt  = if_elig;
        dbg_gnt = dbg_elig;
      end
`endif
    end

    if (if_gnt) begin
      if_state_next = FULL;
    end else if (if_drain) begin
      if_state_next = EMPTY;
    end

    if (dbg_gnt) begin
      dbg_state_next = FULL;
    end else if (dbg_drain) begin
      dbg_state_next = EMPTY;
    end
  end

  assign gnt_addr  = if_gnt  ? bus.if_addr_i :
                     dbg_gnt ? bus.dbg_addr_i : '0;
  assign gnt_err   = addr_bad(gnt_addr);
  // The ROM is still read for an errored grant; only its data is discarded.
  assign load_data = gnt_err ? '0 : bus.rom_inst_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_state  <= EMPTY;
      dbg_state <= EMPTY;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      dbg_rdata <= '0;
      dbg_err   <= 1'b0;
    end else begin
      if_state  <= if_state_next;
      dbg_state <= dbg_state_next;

      if (if_gnt) begin
        if_rdata <= load_data;
        if_err   <= gnt_err;
      end else if (if_drain) begin
        if_rdata <= '0;
        if_err   <= 1'b0;
      end

      if (dbg_gnt) begin
        dbg_rdata <= load_data;
        dbg_err   <= gnt_err;
      end else if (dbg_drain) begin
        dbg_rdata <= '0;
        dbg_err   <= 1'b0;
      end
    end
  end

  assign bus.if_gnt_o     = if_gnt;
  assign bus.if_rvalid_o  = (if_state == FULL);
  assign bus.if_rdata_o   = if_rdata;
  assign bus.if_err_o     = if_err;
  assign bus.dbg_gnt_o    = dbg_gnt;
  assign bus.dbg_rvalid_o = (dbg_state == FULL);
  assign bus.dbg_rdata_o  = dbg_rdata;
  assign bus.dbg_err_o    = dbg_err;
  assign bus.rom_ce_o     = if_gnt || dbg_gnt;
  assign bus.rom_addr_o   = gnt_addr;

endmodule
